// File: rtl/simon_z_gen.sv
// Simon key-schedule round-constant sequencer: five rotating 62-bit z registers stepped once per round.
// Optional macro SIMON_Z_CONTINUOUS_EN keeps the block in RUN after each wrap instead of returning to IDLE.
module simon_z_gen #(
  parameter int SEQ_LEN = 62
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       step,
  output logic       z0,
  output logic       z1,
  output logic       z2,
  output logic       z3,
  output logic       z4,
  output logic [5:0] round,
  output logic       busy,
  output logic       done
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  localparam logic [5:0] LAST_ROUND = 6'(SEQ_LEN - 1);

  // Bit SEQ_LEN-1 holds character 0 of each string, so the head is always the MSB.
  localparam logic [4:0][SEQ_LEN-1:0] Z_INIT = {
    62'b11010001111001101011011000000100101110000110010100100111111011,
    62'b11011011101011000110010111100000010010001010011100110100001111,
    62'b10101111011100000011010010011000101000010001111110010110110011,
    62'b10001110111110010011000010110101000111011111001001100001011010,
    62'b11111010001001010110000111001101111101000100101011000011100110
  };

`ifdef SIMON_Z_CONTINUOUS_EN
  localparam state_t WRAP_STATE = S_RUN;
`else
  localparam state_t WRAP_STATE = S_IDLE;
`endif

  state_t                    r_state;
  logic [4:0][SEQ_LEN-1:0]   r_z;
  logic [5:0]                r_round;
  logic                      r_done;

  // NOTE: the sequence registers are reset to their constants (not zero) so z0..z4 show round 0 straight out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_z     <= Z_INIT;
      r_round <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_state <= S_RUN;
        r_z     <= Z_INIT;
        r_round <= '0;
      end else if (r_state == S_RUN && step) begin
        if (r_round == LAST_ROUND) begin
          r_state <= WRAP_STATE;
          r_z     <= Z_INIT;
          r_round <= '0;
          r_done  <= 1'b1;
        end else begin
          for (int i = 0; i < 5; i++) begin
            r_z[i] <= {r_z[i][SEQ_LEN-2:0], r_z[i][SEQ_LEN-1]};
          end
          r_round <= r_round + 6'd1;
        end
      end
    end
  end

  assign z0    = r_z[0][SEQ_LEN-1];
  assign z1    = r_z[1][SEQ_LEN-1];
  assign z2    = r_z[2][SEQ_LEN-1];
  assign z3    = r_z[3][SEQ_LEN-1];
  assign z4    = r_z[4][SEQ_LEN-1];
  assign round = r_round;
  assign busy  = (r_state == S_RUN);
  assign done  = r_done;

endmodule

// File: tb/tb_simon_z_gen.sv
// Scoreboard bench for simon_z_gen: a string-indexed round model predicts every cycle, a monitor compares.
module tb_simon_z_gen;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       step  = 1'b0;
  logic       z0, z1, z2, z3, z4;
  logic [5:0] round;
  logic       busy, done;

  always #5 clock = ~clock;

  simon_z_gen dut (
    .clock(clock), .reset(reset), .start(start), .step(step),
    .z0(z0), .z1(z1), .z2(z2), .z3(z3), .z4(z4),
    .round(round), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [4:0] z;
    logic [5:0] rnd;
    logic       busy;
    logic       done;
  } exp_t;

`ifdef SIMON_Z_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  string z_str [5] = '{
    "11111010001001010110000111001101111101000100101011000011100110",
    "10001110111110010011000010110101000111011111001001100001011010",
    "10101111011100000011010010011000101000010001111110010110110011",
    "11011011101011000110010111100000010010001010011100110100001111",
    "11010001111001101011011000000100101110000110010100100111111011"
  };

  exp_t exp_q[$];
  int   done_cyc_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  event sample_ev;

  int m_round = 0;
  bit m_busy  = 1'b0;
  bit m_done  = 1'b0;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, expv);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    for (int i = 0; i < 5; i++) e.z[i] = (z_str[i][m_round] == "1");
    e.rnd  = 6'(m_round);
    e.busy = m_busy;
    e.done = m_done;
    return e;
  endfunction

  task automatic cycle(input bit s, input bit st);
    @(negedge clock);
    start = s;
    step  = st;
    if (s) begin
      m_round = 0; m_busy = 1'b1; m_done = 1'b0;
    end else if (m_busy && st) begin
      if (m_round == 61) begin
        m_round = 0; m_done = 1'b1; m_busy = CONT;
      end else begin
        m_round++; m_done = 1'b0;
      end
    end else begin
      m_done = 1'b0;
    end
    exp_q.push_back(model_out());
  endtask

  // Reset is pulsed between edges; the monitor samples while it is still asserted.
  task automatic async_reset();
    @(negedge clock);
    start = 1'b0;
    step  = 1'b0;
    #2 reset = 1'b1;
    m_round = 0; m_busy = 1'b0; m_done = 1'b0;
    exp_q.push_back(model_out());
    -> sample_ev;
    #2 reset = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clock or sample_ev);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("z4..z0", int'({z4, z3, z2, z1, z0}), int'(e.z));
        check("round", int'(round), int'(e.rnd));
        check("busy", int'(busy), int'(e.busy));
        check("done", int'(done), int'(e.done));
        if (done === 1'b1) done_cyc_q.push_back(cyc);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    async_reset();

    // Full pass bit-exact against the strings, then wrap.
    cycle(1'b1, 1'b0);
    repeat (62) cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);

    // Step while idle must not move anything.
    async_reset();
    repeat (10) cycle(1'b0, 1'b1);

    // start beats step at round 30.
    cycle(1'b1, 1'b0);
    repeat (30) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b0);

    // Asynchronous reset at round 40, then a normal run.
    cycle(1'b1, 1'b0);
    repeat (40) cycle(1'b0, 1'b1);
    async_reset();
    cycle(1'b1, 1'b0);
    repeat (5) cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);

    // 124 back-to-back steps: two passes when continuous, one otherwise.
    @(posedge clock);
    #3;
    done_cyc_q.delete();
    cycle(1'b1, 1'b0);
    repeat (124) cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    @(posedge clock);
    #3;
`ifdef SIMON_Z_CONTINUOUS_EN
    if (done_cyc_q.size() == 2) check("done_gap", done_cyc_q[1] - done_cyc_q[0], 62);
    else check("done_count", done_cyc_q.size(), 2);
`else
    check("done_count", done_cyc_q.size(), 1);
`endif

    // Randomised traffic with occasional restarts and resets.
    repeat (2000) begin
      if ($urandom_range(0, 299) == 0) async_reset();
      else cycle($urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0);
    end
    cycle(1'b0, 1'b0);
    @(posedge clock);
    #3;
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/simon_z_gen.md
# simon_z_gen

Round-constant sequencer for the Simon key schedule. Holds the five standard 62-bit constant sequences z0..z4 and presents the current-round bit of each as five 1-bit outputs. These outputs drive the five data inputs of the downstream 5-way constant-select mux, whose 3-bit select picks the sequence for the configured block/key size. The block steps one bit per key-schedule round under a start/step handshake from the key-schedule controller.

## Interface

Parameters:
- `SEQ_LEN`, default 62: sequence length in bits. Fixed at 62; other values are unsupported.

Ports:
- `clock`  input  1  rising-edge clock; the single clock of the block.
- `reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  single-cycle pulse; (re)starts the sequence at round 0.
- `step`   input  1  advance one round; honoured only while `busy`.
- `z0`..`z4`  output  1 each  current-round bit of sequences z0..z4, feeding mux in0..in4.
- `round`  output  6  current round index, 0..61.
- `busy`   output  1  a sequence run is active.
- `done`   output  1  one-cycle pulse on the step that consumes round 61.

## Operation

- Storage: five 62-bit rotating registers, one per sequence. Bit j of zi is character j, counted from the left, of the standard string.
  - z0 = 11111010001001010110000111001101111101000100101011000011100110
  - z1 = 10001110111110010011000010110101000111011111001001100001011010
  - z2 = 10101111011100000011010010011000101000010001111110010110110011
  - z3 = 11011011101011000110010111100000010010001010011100110100001111
  - z4 = 11010001111001101011011000000100101110000110010100100111111011
- `zi` = head bit of register i = bit `round` of zi.
- States: IDLE (`busy`=0) and RUN (`busy`=1).
- IDLE behaviour:
  - `start` loads all registers with their constants, sets `round`=0 and moves to RUN.
  - `step` is ignored.
- RUN behaviour:
  - `step` rotates every register left by one and increments `round`.
  - At `round`=61, `step` reloads the constants, sets `round`=0 and pulses `done`. The next state is set by the macro (see Configuration).
- Priority: `start` beats `step` in the same cycle. Asserting `start` in RUN restarts at round 0 with no `done` pulse.
- `round` never exceeds 61. Every wrap returns it to 0.

## Timing

- Reset values:
  - `round`=0, `busy`=0, `done`=0.
  - Registers hold their constants, so `z0..z4`=1,1,1,1,1.
- All outputs are registered and change only on the `clock` rising edge, except under asynchronous `reset`.
- Latency: `start` or `step` sampled at edge N gives the new `round`/`zi` valid from after edge N. This is one-cycle latency.
- `done` is high for exactly the cycle after the wrapping edge.
- Asynchronous `reset` mid-run forces reset values immediately, without waiting for a clock edge. Any step in flight is lost.
- Back-to-back `step` on every cycle is supported: one round per cycle, 62 cycles per sequence.

## Configuration

- Macro `SIMON_Z_CONTINUOUS_EN`.
- Defined: after the wrap at round 61, the block stays in RUN (`busy`=1), so stepping continues into round 0 of the next pass. `done` still pulses once per wrap.
- Undefined: after the wrap the block returns to IDLE (`busy`=0). A further `start` is required before stepping resumes.

## Test plan

- Reset, then `start`:
  - `round`=0 with `z0..z4`=1,1,1,1,1.
  - One `step` gives `round`=1 with 1,0,0,1,1.
  - A second `step` gives `round`=2 with 1,0,1,0,0.
- `start` then 62 consecutive `step`:
  - The serialised `zi` stream equals the five strings above, bit-exact.
  - `done` is high for one cycle after the 62nd step and `round`=0.
  - Without the macro, `busy`=0. With it, `busy`=1.
- `step` while IDLE for 10 cycles:
  - `round` stays 0, the `zi` outputs do not change and `done`=0.
- At `round`=30, assert `start` and `step` in the same cycle:
  - Next cycle `round`=0, `zi`=1,1,1,1,1, `busy`=1, `done`=0.
- At `round`=40, pulse `reset` asynchronously between clock edges:
  - All outputs return immediately to reset values.
  - A subsequent `start` runs normally.
- With `SIMON_Z_CONTINUOUS_EN` defined, run 124 consecutive steps:
  - Two `done` pulses, spaced 62 cycles apart.
  - The second pass's stream matches the first.
